// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one fixed-latency memory port between the CPU's
//                instruction-fetch and data (load/store) requesters. Data
//                has priority; a starvation counter forces a fetch grant
//                after STARVE_MAX consecutive data grants.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W     = 10,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch requester
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  // data requester
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  // memory port
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [1:0] c_st_idle  = 2'd0;
  localparam logic [1:0] c_st_issue = 2'd1;
  localparam logic [1:0] c_st_wait  = 2'd2;
  localparam logic [1:0] c_st_resp  = 2'd3;

  // WAIT lasts MEM_LAT-1 cycles; zero means ISSUE goes straight to RESP
  localparam logic [2:0] c_wait_load  = 3'(MEM_LAT - 1);
  localparam logic [3:0] c_starve_max = 4'(STARVE_MAX);

  logic [1:0]        r_state;
  logic [1:0]        w_next_state;
  logic              r_win_d;      // current transaction belongs to data
  logic [3:0]        r_starve;
  logic [2:0]        r_wait_cnt;
  logic              r_mem_en;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic              w_arb_slot;
  logic              w_launch;
  logic              w_pick_data;

  // Arbitration only happens in IDLE and RESP; the starved fetch beats data
  assign w_arb_slot  = (r_state == c_st_idle) || (r_state == c_st_resp);
  assign w_launch    = w_arb_slot && (if_req || d_req);
  assign w_pick_data = d_req && !(if_req && (r_starve == c_starve_max));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: begin
        if (w_launch) w_next_state = c_st_issue;
      end
      c_st_issue: begin
        if (r_mem_we)                     w_next_state = c_st_idle;
        else if (c_wait_load != 3'd0)     w_next_state = c_st_wait;
        else                              w_next_state = c_st_resp;
      end
      c_st_wait: begin
        if (r_wait_cnt == 3'd1) w_next_state = c_st_resp;
      end
      c_st_resp: begin
        w_next_state = w_launch ? c_st_issue : c_st_idle;
      end
      default: w_next_state = c_st_idle;
    endcase
  end

  // Winner latch, registered memory strobes, wait and starvation counters
  always_ff @(posedge clk) begin
    if (rst) begin
      r_win_d     <= 1'b0;
      r_starve    <= 4'd0;
      r_wait_cnt  <= 3'd0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_en <= w_launch;
      r_mem_we <= w_launch && w_pick_data && d_we;
      if (w_launch) begin
        r_win_d     <= w_pick_data;
        r_mem_addr  <= w_pick_data ? d_addr : if_addr;
        r_mem_wdata <= w_pick_data ? d_wdata : '0;
      end
      if (r_state == c_st_issue) begin
        r_wait_cnt <= c_wait_load;
        // a data grant with fetch waiting counts towards starvation
        if (r_win_d && if_req) begin
          if (r_starve != c_starve_max) r_starve <= r_starve + 4'd1;
        end else begin
          r_starve <= 4'd0;
        end
      end else if (r_state == c_st_wait) begin
        r_wait_cnt <= r_wait_cnt - 3'd1;
      end
    end
  end

  // Grant, response and status outputs decoded from the state
  always_comb begin
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    if_rdata  = '0;
    d_rdata   = '0;
    case (r_state)
      c_st_issue: begin
        if_gnt = !r_win_d;
        d_gnt  = r_win_d;
      end
      c_st_resp: begin
        if (r_win_d) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
        end else begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
        end
      end
      default: ;
    endcase
    busy = (r_state != c_st_idle);
  end

  assign mem_en    = r_mem_en;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_port_arbiter
//  Description : Self-checking bench for mem_port_arbiter with a behavioural
//                fixed-latency memory and per-requester read scoreboards.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int LAT    = 2;
  localparam int STARVE = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              if_req, if_gnt, if_rvalid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              d_req, d_we, d_gnt, d_rvalid;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(LAT), .STARVE_MAX(STARVE)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // behavioural memory: read data appears LAT cycles after the mem_en cycle
  logic [DATA_W-1:0] mem_m  [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] shadow [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rpipe  [0:LAT-1];

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) begin
      mem_m[i]  = 32'hC0DE_0000 ^ (i * 32'h0001_0103);
      shadow[i] = 32'hC0DE_0000 ^ (i * 32'h0001_0103);
    end
  end

  always @(posedge clk) begin
    if (mem_en && mem_we) mem_m[mem_addr] <= mem_wdata;
    rpipe[0] <= (mem_en && !mem_we) ? mem_m[mem_addr] : 32'hBAD0_BAD0;
    for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
  end
  assign mem_rdata = rpipe[LAT-1];

  // scoreboards: expected read data per requester, in issue order
  logic [DATA_W-1:0] sb_if[$];
  logic [DATA_W-1:0] sb_d[$];
  logic              prev_en = 1'b0;

  // cycle monitor: protocol invariants and response scoreboarding
  always @(negedge clk) begin
    if (!rst) begin
      chk("en_b2b", {31'd0, mem_en & prev_en}, 32'd0);
      chk("gnt_vs_en", {31'd0, if_gnt | d_gnt}, {31'd0, mem_en});
      if (if_rvalid) begin
        if (sb_if.size() == 0) chk("if_rvalid_unexpected", 32'd1, 32'd0);
        else chk("if_rdata", if_rdata, sb_if.pop_front());
      end
      if (d_rvalid) begin
        if (sb_d.size() == 0) chk("d_rvalid_unexpected", 32'd1, 32'd0);
        else chk("d_rdata", d_rdata, sb_d.pop_front());
      end
    end
    prev_en <= mem_en;
  end

  task automatic wait_gnt(output bit is_f, output int at, output bit ok);
    ok = 1'b0; is_f = 1'b0; at = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (if_gnt || d_gnt) begin
        ok = 1'b1; is_f = if_gnt; at = cyc;
        return;
      end
    end
    chk("gnt_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    bit is_f, ok;
    int at, last, seen;

    rst = 1'b1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0;
    d_addr = '0; d_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_flags", {25'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, 32'd0);
    chk("rst_addr", {22'd0, mem_addr}, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single fetch read
    if_req = 1; if_addr = 10'h004; sb_if.push_back(shadow[10'h004]);
    @(negedge clk);
    chk("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    chk("t1_mem_en", {31'd0, mem_en}, 32'd1);
    chk("t1_mem_we", {31'd0, mem_we}, 32'd0);
    chk("t1_mem_addr", {22'd0, mem_addr}, 32'h004);
    chk("t1_busy", {31'd0, busy}, 32'd1);
    if_req = 0;
    for (int k = 2; k <= LAT; k++) begin
      @(negedge clk);
      chk("t1_rvalid_early", {31'd0, if_rvalid}, 32'd0);
      chk("t1_busy_wait", {31'd0, busy}, 32'd1);
    end
    @(negedge clk);
    chk("t1_rvalid", {31'd0, if_rvalid}, 32'd1);
    chk("t1_busy_resp", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("t1_idle", {31'd0, busy}, 32'd0);

    // data write followed by a read of the same word
    d_req = 1; d_we = 1; d_addr = 10'h010; d_wdata = 32'hDEADBEEF;
    shadow[10'h010] = 32'hDEADBEEF;
    @(negedge clk);
    chk("t2_w_gnt", {31'd0, d_gnt}, 32'd1);
    chk("t2_w_we", {31'd0, mem_we}, 32'd1);
    chk("t2_w_addr", {22'd0, mem_addr}, 32'h010);
    chk("t2_w_data", mem_wdata, 32'hDEADBEEF);
    d_we = 0; sb_d.push_back(shadow[10'h010]);
    @(negedge clk);
    chk("t2_w_idle", {29'd0, d_gnt, mem_en, busy}, 32'd0);
    @(negedge clk);
    chk("t2_r_gnt", {31'd0, d_gnt}, 32'd1);
    chk("t2_r_we", {31'd0, mem_we}, 32'd0);
    d_req = 0;
    for (int k = 2; k <= LAT; k++) begin
      @(negedge clk);
      chk("t2_rvalid_early", {31'd0, d_rvalid}, 32'd0);
    end
    @(negedge clk);
    chk("t2_rvalid", {31'd0, d_rvalid}, 32'd1);
    repeat (2) @(negedge clk);

    // contention: both held, expect STARVE data grants then one fetch
    d_we = 0; d_addr = 10'h200; if_addr = 10'h300; d_req = 1; if_req = 1;
    last = 0;
    for (int g = 0; g < 2 * (STARVE + 1); g++) begin
      wait_gnt(is_f, at, ok);
      if (!ok) break;
      chk("t3_order_is_fetch", {31'd0, is_f}, {31'd0, (g % (STARVE + 1)) == STARVE});
      if (g > 0) chk("t3_period", at - last, LAT + 1);
      last = at;
      if (is_f) begin sb_if.push_back(shadow[if_addr]); if_addr = if_addr + 1'b1; end
      else      begin sb_d.push_back(shadow[d_addr]);   d_addr  = d_addr + 1'b1;  end
    end
    if_req = 0; d_req = 0;
    repeat (LAT + 3) @(negedge clk);

    // writes only: one grant every two cycles
    d_req = 1; d_we = 1; d_addr = 10'h100; d_wdata = $urandom;
    shadow[d_addr] = d_wdata;
    for (int g = 0; g < 4; g++) begin
      wait_gnt(is_f, at, ok);
      if (!ok) break;
      chk("t4_is_data", {31'd0, is_f}, 32'd0);
      if (g > 0) chk("t4_period", at - last, 32'd2);
      last = at;
      if (g < 3) begin
        d_addr = d_addr + 1'b1; d_wdata = $urandom; shadow[d_addr] = d_wdata;
      end else begin
        d_req = 0;
      end
    end
    @(negedge clk);
    d_req = 1; d_we = 0; d_addr = 10'h102; sb_d.push_back(shadow[10'h102]);
    wait_gnt(is_f, at, ok);
    d_req = 0;
    repeat (LAT + 3) @(negedge clk);

    // reset while the read waits for memory
    if_req = 1; if_addr = 10'h020;
    @(negedge clk);
    chk("t5_gnt", {31'd0, if_gnt}, 32'd1);
    if_req = 0;
    @(negedge clk);
    chk("t5_busy_wait", {31'd0, busy}, 32'd1);
    rst = 1;
    @(negedge clk);
    chk("t5_rst_flags", {25'd0, if_gnt, d_gnt, if_rvalid, d_rvalid, mem_en, mem_we, busy}, 32'd0);
    chk("t5_rst_addr", {22'd0, mem_addr}, 32'd0);
    rst = 0;
    seen = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (if_rvalid || d_rvalid || busy) seen++;
    end
    chk("t5_no_resp_after_abort", seen, 32'd0);

    // fetch already pending in the RESP cycle of a data read
    d_req = 1; d_we = 0; d_addr = 10'h010; sb_d.push_back(shadow[10'h010]);
    @(negedge clk);
    chk("t6_d_gnt", {31'd0, d_gnt}, 32'd1);
    d_req = 0; if_req = 1; if_addr = 10'h005; sb_if.push_back(shadow[10'h005]);
    for (int k = 2; k <= LAT; k++) begin
      @(negedge clk);
      chk("t6_if_gnt_early", {31'd0, if_gnt}, 32'd0);
    end
    @(negedge clk);
    chk("t6_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    chk("t6_if_gnt_in_resp", {31'd0, if_gnt}, 32'd0);
    @(negedge clk);
    chk("t6_if_gnt", {31'd0, if_gnt}, 32'd1);
    if_req = 0;
    repeat (LAT + 3) @(negedge clk);

    chk("sb_if_drained", sb_if.size(), 32'd0);
    chk("sb_d_drained", sb_d.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates a single-port unified memory between the CPU's instruction-fetch requester and its data (load/store) requester. It sits between the fetch/data stages and one memory port of configurable fixed read latency, and returns per-requester grants and read responses. Arbitration gives data priority, and a starvation counter guarantees fetch progress. The CPU stalls a stage until that stage's grant and, for reads, its response arrive.

## Interface
- ADDR_W, 10: memory word-address width.
- DATA_W, 32: data width.
- MEM_LAT, 1: memory read latency in cycles, range 1..4. Read data is valid MEM_LAT cycles after the mem_en cycle.
- STARVE_MAX, 4: consecutive data grants with a fetch pending, after which fetch wins. Range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- if_req  in  1  fetch request; held high until if_gnt.
- if_addr  in  ADDR_W  fetch address; held stable with if_req.
- if_gnt  out  1  one-cycle grant pulse for fetch.
- if_rvalid  out  1  one-cycle pulse; if_rdata is valid.
- if_rdata  out  DATA_W  fetch read data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = write, 0 = read; held with d_req.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_gnt  out  1  one-cycle grant pulse for data.
- d_rvalid  out  1  one-cycle pulse, data reads only.
- d_rdata  out  DATA_W  data read data.
- mem_en  out  1  memory access strobe, registered.
- mem_we  out  1  memory write enable, registered.
- mem_addr  out  ADDR_W  registered address.
- mem_wdata  out  DATA_W  registered write data.
- mem_rdata  in  DATA_W  memory read data.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Arbitration is evaluated only in the IDLE and RESP cycles.
  - If any request is pending, the winner is latched and the FSM goes to ISSUE on the next edge.
  - Otherwise the FSM goes to (or stays in) IDLE.
- Winner rule:
  - Only one requester pending: that requester wins.
  - Both pending: data wins, unless starve_cnt == STARVE_MAX, in which case fetch wins.
- starve_cnt:
  - Increments (saturating at STARVE_MAX) on a data grant while if_req is high.
  - Clears on any fetch grant, and on a data grant while if_req is low.
- ISSUE (exactly 1 cycle):
  - mem_en = 1, plus mem_we/mem_addr/mem_wdata of the winner.
  - The winner's gnt = 1.
  - Request inputs are ignored in this cycle; the requester is still holding req.
  - Next state: IDLE for a write. For a read, WAIT if MEM_LAT > 1, else RESP.
- WAIT: holds for MEM_LAT−1 cycles via a down-counter, then goes to RESP.
- RESP (1 cycle):
  - The winner's rvalid = 1.
  - The winner's rdata = mem_rdata, combinational pass-through.
  - The rdata port of the non-winning requester is don't-care.
- At most one transaction is outstanding. Writes produce no rvalid.
- mem_en = 0 in all states other than ISSUE. mem_we is only meaningful when mem_en = 1 and is driven 0 otherwise.

## Timing
- Reset (synchronous): state IDLE, starve_cnt 0.
  - All outputs 0: gnt, rvalid, mem_en, mem_we, mem_addr, mem_wdata, busy.
  - Reset asserted mid-transaction aborts it: no rvalid is issued, and a pending WAIT/RESP is dropped.
- A request arriving in IDLE at cycle t gets gnt and mem_en at t+1.
- Read latency: rvalid at t+1+MEM_LAT.
- Throughput:
  - Back-to-back reads: one issue every MEM_LAT+2 cycles from IDLE, or MEM_LAT+1 when the next request is already pending in RESP.
  - Back-to-back writes: one issue every 2 cycles (ISSUE → IDLE → ISSUE).
- Requests arriving during ISSUE or WAIT are held by the requester and arbitrated at the next IDLE/RESP.
- Both requests rising in the same cycle is an ordinary contention case and follows the winner rule.

## Test plan
- Single fetch read, MEM_LAT=2: if_req=1, if_addr=0x004 at cycle 0.
  - Required: if_gnt, mem_en, mem_addr=0x004 at cycle 1; if_rvalid at cycle 3; if_rdata = memory word 0x004; busy high in cycles 1–3.
- Data write then read, MEM_LAT=1:
  - Write d_addr=0x010, d_wdata=0xDEADBEEF. Required: d_gnt, mem_we=1 at cycle 1; no d_rvalid.
  - Read 0x010 presented at cycle 2. Required: d_gnt at cycle 3; d_rvalid with d_rdata=0xDEADBEEF at cycle 4.
- Contention, STARVE_MAX=4: d_req and if_req held continuously.
  - Required: 4 data grants, then 1 fetch grant; the pattern repeats, and the fetch grant clears starve_cnt.
- Writes only: d_req held high with d_we=1, new address after each grant.
  - Required: d_gnt every 2 cycles and mem_en never on consecutive cycles.
- Reset during WAIT (MEM_LAT=3): assert rst at cycle 2 after a read issue.
  - Required: the next cycle shows all outputs 0 and state IDLE; no rvalid ever appears for the aborted read.
- Request pending in RESP, MEM_LAT=1: if_req already high during the RESP cycle of a data read.
  - Required: if_gnt the cycle immediately after d_rvalid.
